// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory arbiter: FSM state, owner tag and response codes.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IFU  = 2'd1,
        LSU  = 2'd2
    } arb_owner_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of IFU, LSU and memory-side signals for mem_arbiter.
// The slave modport is the arbiter; the master modport is the surrounding system.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int MASK_W = DATA_W / 8;

    logic              ifu_req_i;
    logic [ADDR_W-1:0] ifu_addr_i;
    logic              ifu_gnt_o;
    logic              ifu_rvalid_o;
    logic [DATA_W-1:0] ifu_rdata_o;
    logic [1:0]        ifu_resp_o;

    logic              lsu_req_i;
    logic              lsu_wen_i;
    logic [ADDR_W-1:0] lsu_addr_i;
    logic [DATA_W-1:0] lsu_wdata_i;
    logic [MASK_W-1:0] lsu_mask_i;
    logic              lsu_gnt_o;
    logic              lsu_rvalid_o;
    logic [DATA_W-1:0] lsu_rdata_o;
    logic [1:0]        lsu_resp_o;

    logic              mem_ren_o;
    logic              mem_wen_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [MASK_W-1:0] mem_we_mask_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic [1:0]        mem_resp_i;

    modport slave (
        input  ifu_req_i, ifu_addr_i,
        output ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o, ifu_resp_o,
        input  lsu_req_i, lsu_wen_i, lsu_addr_i, lsu_wdata_i, lsu_mask_i,
        output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_resp_o,
        output mem_ren_o, mem_wen_o, mem_addr_o, mem_wdata_o, mem_we_mask_o,
        input  mem_rdata_i, mem_resp_i
    );

    modport master (
        output ifu_req_i, ifu_addr_i,
        input  ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o, ifu_resp_o,
        output lsu_req_i, lsu_wen_i, lsu_addr_i, lsu_wdata_i, lsu_mask_i,
        input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_resp_o,
        input  mem_ren_o, mem_wen_o, mem_addr_o, mem_wdata_o, mem_we_mask_o,
        output mem_rdata_i, mem_resp_i
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between IFU and LSU.
// MEM_ARBITER_RR_EN selects round-robin; otherwise LSU has fixed priority.
module mem_arb_pick (
    input  logic ifu_req_i,
    input  logic lsu_req_i,
`ifdef MEM_ARBITER_RR_EN
    input  logic last_lsu_i,
`endif
    output logic pick_ifu_o,
    output logic pick_lsu_o
);

    always_comb begin
`ifdef MEM_ARBITER_RR_EN
        // On a tie the side that was not granted last wins.
        pick_lsu_o = lsu_req_i && (!ifu_req_i || !last_lsu_i);
`else
        pick_lsu_o = lsu_req_i;
`endif
        pick_ifu_o = ifu_req_i && !pick_lsu_o;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) single-outstanding memory arbiter, one transaction per two cycles.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; default is LSU-over-IFU fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mem_arbiter_if.slave   bus,
    output arb_state_e     state_o,
    output arb_owner_e     owner_o
);

    localparam int MASK_W = DATA_W / 8;

    // Handshake: a requester holds req and payload until it sees gnt in the
    // same cycle; gnt means the command is on mem_* now, and exactly one
    // rvalid pulse for that requester follows on the next cycle.

    arb_state_e state_q, state_d;
    arb_owner_e owner_q, owner_d;
    logic       pick_ifu, pick_lsu;

`ifdef MEM_ARBITER_RR_EN
    logic last_lsu_q;

    mem_arb_pick u_pick (
        .ifu_req_i  (bus.ifu_req_i),
        .lsu_req_i  (bus.lsu_req_i),
        .last_lsu_i (last_lsu_q),
        .pick_ifu_o (pick_ifu),
        .pick_lsu_o (pick_lsu)
    );
`else
    mem_arb_pick u_pick (
        .ifu_req_i  (bus.ifu_req_i),
        .lsu_req_i  (bus.lsu_req_i),
        .pick_ifu_o (pick_ifu),
        .pick_lsu_o (pick_lsu)
    );
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= NONE;
`ifdef MEM_ARBITER_RR_EN
            last_lsu_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
`ifdef MEM_ARBITER_RR_EN
            if (state_q == IDLE && (pick_ifu || pick_lsu)) begin
                last_lsu_q <= pick_lsu;
            end
`endif
        end
    end

    always_comb begin
        state_d           = state_q;
        owner_d           = owner_q;
        bus.ifu_gnt_o     = 1'b0;
        bus.ifu_rvalid_o  = 1'b0;
        bus.ifu_rdata_o   = {DATA_W{1'b0}};
        bus.ifu_resp_o    = 2'b00;
        bus.lsu_gnt_o     = 1'b0;
        bus.lsu_rvalid_o  = 1'b0;
        bus.lsu_rdata_o   = {DATA_W{1'b0}};
        bus.lsu_resp_o    = 2'b00;
        bus.mem_ren_o     = 1'b0;
        bus.mem_wen_o     = 1'b0;
        bus.mem_addr_o    = {ADDR_W{1'b0}};
        bus.mem_wdata_o   = {DATA_W{1'b0}};
        bus.mem_we_mask_o = {MASK_W{1'b0}};
        state_o           = IDLE;
        owner_o           = NONE;

        // Every output, including the combinational grants, is held at zero in reset.
        if (!rst_i) begin
            state_o = state_q;
            owner_o = owner_q;
            case (state_q)
                IDLE: begin
                    if (pick_lsu) begin
                        bus.lsu_gnt_o  = 1'b1;
                        bus.mem_addr_o = bus.lsu_addr_i;
                        if (bus.lsu_wen_i) begin
                            bus.mem_wen_o     = 1'b1;
                            bus.mem_wdata_o   = bus.lsu_wdata_i;
                            bus.mem_we_mask_o = bus.lsu_mask_i;
                        end else begin
                            bus.mem_ren_o = 1'b1;
                        end
                        owner_d = LSU;
                        state_d = WAIT;
                    end else if (pick_ifu) begin
                        bus.ifu_gnt_o  = 1'b1;
                        bus.mem_ren_o  = 1'b1;
                        bus.mem_addr_o = bus.ifu_addr_i;
                        owner_d = IFU;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (owner_q == IFU) begin
                        bus.ifu_rvalid_o = 1'b1;
                        bus.ifu_rdata_o  = bus.mem_rdata_i;
                        bus.ifu_resp_o   = bus.mem_resp_i;
                    end else if (owner_q == LSU) begin
                        bus.lsu_rvalid_o = 1'b1;
                        bus.lsu_rdata_o  = bus.mem_rdata_i;
                        bus.lsu_resp_o   = bus.mem_resp_i;
                    end
                    owner_d = NONE;
                    state_d = IDLE;
                end
                default: begin
                    owner_d = NONE;
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule
